// File: rtl/pllc_pkg.sv
// rtl/pllc_pkg.sv - shared types and divider encoding for the PLL reconfiguration controller
package pllc_pkg;

  typedef enum logic [1:0] {
    HOLD,
    WAIT,
    LOCKED,
    FAIL
  } pllc_state_e;

  typedef logic [5:0] pllc_div_t;

  // The PLL dynamic select inputs take the inverted divider-minus-one value
  function automatic pllc_div_t div_to_sel(input pllc_div_t div);
    return ~div;
  endfunction

endpackage

// File: rtl/pllc_lock_filt.sv
// rtl/pllc_lock_filt.sv - lock synchronizer and consecutive-high lock filter
module pllc_lock_filt #(
  parameter int LOCK_FILT = 16
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic en,
  input  logic pll_lock,
  output logic lock_s,
  output logic lock_ok
);

  localparam int FW = $clog2(LOCK_FILT + 1);

  logic          meta_q;
  logic [FW-1:0] cnt_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      meta_q <= pll_lock;
      lock_s <= meta_q;
    end
  end

  // lock_ok marks the LOCK_FILT-th consecutive high cycle, so the counter never needs to hold LOCK_FILT
  assign lock_ok = en && lock_s && (cnt_q == FW'(LOCK_FILT - 1));

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en && lock_s && !lock_ok) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/pll_reconf_ctrl.sv
// rtl/pll_reconf_ctrl.sv - PLL reset/lock sequencer with divider reconfiguration requests
// Define PLLC_AUTO_RELOCK_EN to re-reset the PLL on loss of lock and count relock events.
module pll_reconf_ctrl
  import pllc_pkg::*;
#(
  parameter int        LOCK_FILT    = 16,
  parameter int        LOCK_TIMEOUT = 65535,
  parameter int        RST_HOLD     = 8,
  parameter int        RETRY_MAX    = 3,
  parameter pllc_div_t INIT_IDIV    = 6'd3,
  parameter pllc_div_t INIT_FBDIV   = 6'd4,
  parameter pllc_div_t INIT_ODIV    = 6'd8
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_idiv,
  input  logic [5:0] req_fbdiv,
  input  logic [5:0] req_odiv,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       locked,
  output logic       user_rst_n,
  output logic       busy,
  output logic       err,
  output logic [7:0] relock_cnt
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RW = $clog2(RETRY_MAX + 1);

  pllc_state_e   state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          lock_s, lock_ok, lost, accept;

  pllc_lock_filt #(
    .LOCK_FILT(LOCK_FILT)
  ) u_lock_filt (
    .clkin   (clkin),
    .rst_n   (rst_n),
    .en      (state_q == WAIT),
    .pll_lock(pll_lock),
    .lock_s  (lock_s),
    .lock_ok (lock_ok)
  );

  // Loss of lock outranks a same-cycle request by hiding ready
  assign lost      = (state_q == LOCKED) && !lock_s;
  assign req_ready = (state_q == FAIL) || ((state_q == LOCKED) && lock_s);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wait_cnt_d = wait_cnt_q;
    retry_d    = retry_q;
    unique case (state_q)
      HOLD: begin
        if (hold_cnt_q == HW'(RST_HOLD - 1)) begin
          state_d    = WAIT;
          hold_cnt_d = '0;
          wait_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (lock_ok) begin
          state_d = LOCKED;
          retry_d = '0;
        end else if (wait_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
          retry_d    = retry_q + 1'b1;
          wait_cnt_d = '0;
          hold_cnt_d = '0;
          state_d    = (retry_d < RW'(RETRY_MAX)) ? HOLD : FAIL;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      LOCKED: begin
        if (lost) begin
`ifdef PLLC_AUTO_RELOCK_EN
          state_d    = HOLD;
          hold_cnt_d = '0;
`else
          state_d    = WAIT;
          wait_cnt_d = '0;
`endif
        end else if (accept) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          retry_d    = '0;
        end
      end
      FAIL: begin
        if (accept) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          retry_d    = '0;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      retry_q    <= '0;
      pll_reset  <= 1'b1;
      locked     <= 1'b0;
      user_rst_n <= 1'b0;
      busy       <= 1'b1;
      err        <= 1'b0;
      pll_idsel  <= div_to_sel(INIT_IDIV);
      pll_fbdsel <= div_to_sel(INIT_FBDIV);
      pll_odsel  <= div_to_sel(INIT_ODIV);
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      retry_q    <= retry_d;
      pll_reset  <= (state_d == HOLD) || (state_d == FAIL);
      locked     <= (state_d == LOCKED);
      user_rst_n <= (state_d == LOCKED);
      busy       <= (state_d == HOLD) || (state_d == WAIT);
      err        <= (state_d == FAIL);
      if (accept) begin
        pll_idsel  <= div_to_sel(req_idiv);
        pll_fbdsel <= div_to_sel(req_fbdiv);
        pll_odsel  <= div_to_sel(req_odiv);
      end
    end
  end

`ifdef PLLC_AUTO_RELOCK_EN
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      relock_cnt <= '0;
    end else if (lost && (relock_cnt != 8'hFF)) begin
      relock_cnt <= relock_cnt + 1'b1;
    end
  end
`else
  assign relock_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reconf_ctrl.sv
// tb/tb_pll_reconf_ctrl.sv - scoreboard bench for pll_reconf_ctrl
module tb_pll_reconf_ctrl;

  localparam int LF = 16;
  localparam int LT = 100;
  localparam int RH = 8;
  localparam int RM = 3;
  localparam logic [17:0] INIT_SEL = 18'b111100_111011_110111;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [5:0] req_idiv = '0, req_fbdiv = '0, req_odiv = '0;
  logic       pll_lock = 1'b0;
  logic       req_ready, pll_reset, locked, user_rst_n, busy, err;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [7:0] relock_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [17:0] exp_q[$];
  logic [17:0] cur_sel = INIT_SEL;

  pll_reconf_ctrl #(
    .LOCK_FILT(LF), .LOCK_TIMEOUT(LT), .RST_HOLD(RH), .RETRY_MAX(RM)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_idiv(req_idiv), .req_fbdiv(req_fbdiv), .req_odiv(req_odiv),
    .pll_lock(pll_lock), .pll_reset(pll_reset), .pll_idsel(pll_idsel),
    .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel), .locked(locked),
    .user_rst_n(user_rst_n), .busy(busy), .err(err), .relock_cnt(relock_cnt)
  );

  always #5 clkin = ~clkin;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_req(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
    int n;
    n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clkin);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_wait: got %b expected 1", req_ready);
    end
    req_idiv = i; req_fbdiv = f; req_odiv = o; req_valid = 1'b1;
    cur_sel = {~i, ~f, ~o};
    exp_q.push_back(cur_sel);
    @(negedge clkin);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_lock = 1'b0; req_valid = 1'b0;
    repeat (3) @(negedge clkin);
    checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL reset_pll_reset: got %b expected 1", pll_reset); end
    checks++; if ({locked, user_rst_n, err, req_ready} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {locked, user_rst_n, err, req_ready}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++; if (relock_cnt !== 8'd0) begin errors++; $display("FAIL reset_relock: got %0d expected 0", relock_cnt); end
    checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== INIT_SEL) begin errors++; $display("FAIL reset_sel: got %h expected %h", {pll_idsel, pll_fbdsel, pll_odsel}, INIT_SEL); end
  endtask

  task automatic test_bringup();
    int n;
    rst_n = 1'b1;
    n = 0;
    while (pll_reset && n < 50) begin
      n++;
      @(negedge clkin);
    end
    checks++; if (n != RH) begin errors++; $display("FAIL bringup_hold_len: got %0d expected %0d", n, RH); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bringup_wait_busy: got %b expected 1", busy); end
    repeat (5) @(negedge clkin);
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 200) begin
      @(negedge clkin);
      n++;
    end
    checks++; if (n != 2 + LF) begin errors++; $display("FAIL bringup_lock_latency: got %0d expected %0d", n, 2 + LF); end
    checks++; if ({user_rst_n, busy, req_ready} !== 3'b101) begin errors++; $display("FAIL bringup_status: got %b expected 101", {user_rst_n, busy, req_ready}); end
    checks++; if (pll_idsel !== 6'b111100) begin errors++; $display("FAIL bringup_idsel: got %b expected 111100", pll_idsel); end
  endtask

  task automatic test_reconfig();
    int n;
    logic [17:0] e;
    send_req(6'd1, 6'd9, 6'd4);
    pll_lock = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL reconfig_sb: got empty expected entry"); end
    else begin
      e = exp_q.pop_front();
      if ({pll_idsel, pll_fbdsel, pll_odsel} !== e) begin errors++; $display("FAIL reconfig_sel: got %h expected %h", {pll_idsel, pll_fbdsel, pll_odsel}, e); end
    end
    checks++; if (pll_fbdsel !== 6'b110110) begin errors++; $display("FAIL reconfig_fbdsel: got %b expected 110110", pll_fbdsel); end
    checks++; if ({locked, user_rst_n, busy} !== 3'b001) begin errors++; $display("FAIL reconfig_hold_status: got %b expected 001", {locked, user_rst_n, busy}); end
    n = 0;
    while (pll_reset && n < 50) begin
      n++;
      @(negedge clkin);
    end
    checks++; if (n != RH) begin errors++; $display("FAIL reconfig_hold_len: got %0d expected %0d", n, RH); end
    req_idiv = 6'h3f; req_fbdiv = 6'h3f; req_odiv = 6'h3f; req_valid = 1'b1;
    repeat (5) @(negedge clkin);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wait_ready: got %b expected 0", req_ready); end
    req_valid = 1'b0;
    @(negedge clkin);
    checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== cur_sel) begin errors++; $display("FAIL wait_req_ignored: got %h expected %h", {pll_idsel, pll_fbdsel, pll_odsel}, cur_sel); end
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 200) begin
      @(negedge clkin);
      n++;
    end
    checks++; if (n != 2 + LF) begin errors++; $display("FAIL reconfig_relock: got %0d expected %0d", n, 2 + LF); end
  endtask

  task automatic test_timeout();
    int n, falls;
    logic prev;
    logic [17:0] e;
    send_req(6'd2, 6'd5, 6'd7);
    pll_lock = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL timeout_sb: got empty expected entry"); end
    else begin
      e = exp_q.pop_front();
      if ({pll_idsel, pll_fbdsel, pll_odsel} !== e) begin errors++; $display("FAIL timeout_sel: got %h expected %h", {pll_idsel, pll_fbdsel, pll_odsel}, e); end
    end
    n = 0; falls = 0; prev = pll_reset;
    while (!err && n < 2000) begin
      @(negedge clkin);
      n++;
      if (prev && !pll_reset) falls++;
      prev = pll_reset;
    end
    checks++; if (n != RM * (RH + LT)) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d", n, RM * (RH + LT)); end
    checks++; if (falls != RM) begin errors++; $display("FAIL timeout_attempts: got %0d expected %0d", falls, RM); end
    checks++; if ({err, pll_reset, busy, req_ready, locked} !== 5'b11010) begin errors++; $display("FAIL fail_status: got %b expected 11010", {err, pll_reset, busy, req_ready, locked}); end
    repeat (10) @(negedge clkin);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL fail_sticky: got %b expected 1", err); end
    send_req(6'd0, 6'd4, 6'd8);
    checks++; if ({err, pll_reset, busy} !== 3'b011) begin errors++; $display("FAIL fail_recover: got %b expected 011", {err, pll_reset, busy}); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL recover_sb: got empty expected entry"); end
    else begin
      e = exp_q.pop_front();
      if ({pll_idsel, pll_fbdsel, pll_odsel} !== e) begin errors++; $display("FAIL recover_sel: got %h expected %h", {pll_idsel, pll_fbdsel, pll_odsel}, e); end
    end
  endtask

  task automatic test_toggle();
    int seen, n;
    seen = 0;
    for (int c = 0; c < 250; c++) begin
      pll_lock = ((c / 5) % 2 == 0);
      @(negedge clkin);
      if (locked) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL toggle_locked: got %0d locked cycles expected 0", seen); end
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 100) begin
      @(negedge clkin);
      n++;
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL toggle_final_lock: got %b expected 1", locked); end
  endtask

  task automatic test_glitch();
    int n;
    checks++; if (relock_cnt !== 8'd0) begin errors++; $display("FAIL glitch_pre_relock: got %0d expected 0", relock_cnt); end
    pll_lock = 1'b0;
    @(negedge clkin);
    pll_lock = 1'b1;
    @(negedge clkin);
    checks++; if ({req_ready, locked} !== 2'b01) begin errors++; $display("FAIL glitch_ready_forced: got %b expected 01", {req_ready, locked}); end
    req_idiv = 6'h15; req_fbdiv = 6'h15; req_odiv = 6'h15; req_valid = 1'b1;
    @(negedge clkin);
    req_valid = 1'b0;
    checks++; if ({locked, user_rst_n, busy} !== 3'b001) begin errors++; $display("FAIL glitch_status: got %b expected 001", {locked, user_rst_n, busy}); end
`ifdef PLLC_AUTO_RELOCK_EN
    checks++; if ({pll_reset, relock_cnt} !== {1'b1, 8'd1}) begin errors++; $display("FAIL glitch_relock: got %b/%0d expected 1/1", pll_reset, relock_cnt); end
`else
    checks++; if ({pll_reset, relock_cnt} !== {1'b0, 8'd0}) begin errors++; $display("FAIL glitch_relock: got %b/%0d expected 0/0", pll_reset, relock_cnt); end
`endif
    checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== cur_sel) begin errors++; $display("FAIL glitch_req_dropped: got %h expected %h", {pll_idsel, pll_fbdsel, pll_odsel}, cur_sel); end
    n = 0;
    while (!locked && n < 200) begin
      @(negedge clkin);
      n++;
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL glitch_relocked: got %b expected 1", locked); end
  endtask

  task automatic test_async_reset();
    int n;
    logic [17:0] e;
    send_req(6'd5, 6'd6, 6'd7);
    pll_lock = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL areset_sb: got empty expected entry"); end
    else begin
      e = exp_q.pop_front();
      if ({pll_idsel, pll_fbdsel, pll_odsel} !== e) begin errors++; $display("FAIL areset_req_sel: got %h expected %h", {pll_idsel, pll_fbdsel, pll_odsel}, e); end
    end
    n = 0;
    while (pll_reset && n < 50) begin
      @(negedge clkin);
      n++;
    end
    repeat (3) @(negedge clkin);
    checks++; if ({pll_reset, busy} !== 2'b01) begin errors++; $display("FAIL areset_in_wait: got %b expected 01", {pll_reset, busy}); end
    @(posedge clkin);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== INIT_SEL) begin errors++; $display("FAIL areset_sel: got %h expected %h", {pll_idsel, pll_fbdsel, pll_odsel}, INIT_SEL); end
    checks++; if ({user_rst_n, pll_reset, busy, req_ready} !== 4'b0110) begin errors++; $display("FAIL areset_status: got %b expected 0110", {user_rst_n, pll_reset, busy, req_ready}); end
    @(negedge clkin);
    rst_n = 1'b1;
    @(negedge clkin);
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_reconfig();
    test_timeout();
    test_toggle();
    test_glitch();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_reconf_ctrl.md
PLL_RECONF_CTRL -- requirements
Module: pll_reconf_ctrl

Interface
REQ-001 SHALL have parameter LOCK_FILT, default 16, which is the number of consecutive synchronized lock-high cycles required before lock is declared.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535, which is the maximum number of cycles spent waiting for lock per attempt.
REQ-003 SHALL have parameter RST_HOLD, default 8, which is the number of cycles pll_reset is held high per attempt.
REQ-004 SHALL have parameter RETRY_MAX, default 3, which is the number of failed lock attempts allowed before entering FAIL.
REQ-005 SHALL have parameter INIT_IDIV / INIT_FBDIV / INIT_ODIV, defaults 3 / 4 / 8, which are the divider-minus-one values loaded at reset.
REQ-006 SHALL have port clkin, input, 1 bit: the single controller clock, which is the PLL reference clock. Reset is asynchronous and active-low.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port req_valid / req_ready, input / output, 1 bit each: reconfiguration request handshake.
REQ-009 SHALL have port req_idiv, req_fbdiv, req_odiv, input, 6 bits each: requested dividers, as divider minus one.
REQ-010 SHALL have port pll_lock, input, 1 bit: raw, asynchronous PLL LOCK.
REQ-011 SHALL have port pll_reset, output, 1 bit: PLL RESET.
REQ-012 SHALL have port pll_idsel, pll_fbdsel, pll_odsel, output, 6 bits each: PLL dynamic select buses.
REQ-013 SHALL have port locked, output, 1 bit: filtered lock indication.
REQ-014 SHALL have port user_rst_n, output, 1 bit: downstream reset, active-low.
REQ-015 SHALL have port busy, err, output, 1 bit each: status.
REQ-016 SHALL have port relock_cnt, output, 8 bits: saturating count of loss-of-lock events.

Function
REQ-017 SHALL pass pll_lock through a 2-FF synchronizer before any use.
REQ-018 SHALL use the states HOLD, WAIT, LOCKED and FAIL.
REQ-019 HOLD: pll_reset=1 for exactly RST_HOLD cycles, then go to WAIT.
REQ-020 WAIT: pll_reset=0; the filter counter increments while the synchronized lock is 1 and clears to 0 when it is 0.
REQ-021 WAIT: when the filter counter reaches LOCK_FILT, go to LOCKED and clear the retry counter.
REQ-022 WAIT timeout: after LOCK_TIMEOUT cycles without lock, increment the retry counter; if retry < RETRY_MAX go to HOLD, otherwise go to FAIL.
REQ-023 FAIL: err=1 and pll_reset=1; the block stays in FAIL until a request is accepted.
REQ-024 LOCKED: locked=1 and user_rst_n=1, both registered and asserted in the first LOCKED cycle.
REQ-025 Outside LOCKED: locked=0 and user_rst_n=0.
REQ-026 req_ready SHALL be 1 only in LOCKED or FAIL.
REQ-027 Request acceptance: a request is accepted on a cycle where req_valid and req_ready are both 1; the req_* dividers are latched, the retry counter is cleared, err is cleared, and the next state is HOLD.
REQ-028 Accepted requests SHALL NOT be queued; req_valid high while req_ready is low has no effect.
REQ-029 Gowin dynamic encoding: pll_xxsel = bitwise-NOT of the latched divider-minus-one, registered, and changed only on the acceptance cycle or at reset.
REQ-030 busy = 1 in HOLD and WAIT, and 0 otherwise.
REQ-031 Synchronized lock low in LOCKED: behaviour is given by REQ-036/037; this event takes priority over a request accepted in the same cycle, and that request is dropped with req_ready forced to 0 that cycle.

Reset
REQ-032 On rst_n low: state=HOLD, pll_reset=1, locked=0, user_rst_n=0, busy=1, err=0, relock_cnt=0, and retry and filter counters at 0.
REQ-033 On rst_n low: pll_idsel / pll_fbdsel / pll_odsel = NOT of INIT_IDIV / INIT_FBDIV / INIT_ODIV, and req_ready=0.
REQ-034 Reset assertion is asynchronous, and deassertion is sampled on clkin.
REQ-035 A reset mid-sequence SHALL abandon the current attempt and reload the INIT dividers.

Configuration
REQ-036 With PLLC_AUTO_RELOCK_EN defined: loss of lock in LOCKED causes a transition to HOLD and increments relock_cnt, saturating at 255.
REQ-037 Without PLLC_AUTO_RELOCK_EN: loss of lock in LOCKED causes a transition to WAIT with no PLL reset and no timeout retry limit change, and relock_cnt is tied to 0.

Structure
REQ-038 Package pllc_pkg SHALL hold the state enum, the 6-bit divider typedef, and the divider-to-select encode function.
REQ-039 Sub-module pllc_lock_filt SHALL contain the synchronizer and the LOCK_FILT counter, and output lock_ok.
REQ-040 The target implementation size is 150-300 lines.

Verification
REQ-041 Release rst_n with pll_lock high from cycle 10 -> pll_reset falls after 8 cycles, locked rises 16 cycles after the synchronized lock, and pll_idsel=6'b111100.
REQ-042 In LOCKED, send a request with idiv=1, fbdiv=9, odiv=4 -> pll_reset=1 for 8 cycles, pll_fbdsel=6'b110110, and locked returns once lock is stable again.
REQ-043 Hold pll_lock low, with LOCK_TIMEOUT=100 -> 3 HOLD/WAIT attempts, then FAIL with err=1; a subsequent request clears err.
REQ-044 Toggle pll_lock with a 10-cycle period in WAIT -> locked never asserts.
REQ-045 Drop pll_lock for 1 cycle in LOCKED -> with the macro: HOLD and relock_cnt=1; without the macro: WAIT and relock_cnt=0.
REQ-046 Assert rst_n low during WAIT after a request -> the INIT selects are restored and user_rst_n=0.
